uart_csr_ctrl: RTL and testbench

Second-generation UART control/status block for the CPU-facing side of the UART. It decodes CPU accesses to six registers and drives the Tx/Rx FIFOs directly: CPU writes push the Tx FIFO, CPU reads pop the Rx FIFO, and received characters are pushed into the Rx FIFO. An internal launch FSM feeds the Tx module from the Tx FIFO. Sticky W1C error/event flags drive a maskable interrupt.

---
 rtl/uart_csr_pkg.sv | 39 +++
 rtl/uart_tx_launch.sv | 52 +++++
 rtl/uart_csr_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_csr_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_csr_pkg.sv
// Shared constants for the UART CSR block: register indices, field positions
// and launch FSM encoding.
package uart_csr_pkg;

    localparam int unsigned IDX_STAT     = 0;
    localparam int unsigned IDX_CTRL     = 1;
    localparam int unsigned IDX_TXDATA   = 2;
    localparam int unsigned IDX_RXDATA   = 3;
    localparam int unsigned IDX_IRQ_EN   = 4;
    localparam int unsigned IDX_IRQ_STAT = 5;

    localparam int unsigned STAT_FSM_ACTIVE = 0;
    localparam int unsigned STAT_TX_BUSY    = 1;
    localparam int unsigned STAT_TX_EMPTY   = 8;
    localparam int unsigned STAT_TX_FULL    = 10;
    localparam int unsigned STAT_RX_BUSY    = 17;
    localparam int unsigned STAT_RX_EMPTY   = 24;
    localparam int unsigned STAT_RX_FULL    = 26;

    localparam int unsigned CTRL_TX_EN       = 0;
    localparam int unsigned CTRL_TX_CONF_LSB = 2;
    localparam int unsigned CTRL_RX_EN       = 16;
    localparam int unsigned CTRL_RX_CONF_LSB = 18;
    localparam int unsigned CTRL_BAUD_LSB    = 30;

    localparam int unsigned IRQ_SRC_N       = 6;
    localparam int unsigned IRQ_RX_AVAIL    = 0;
    localparam int unsigned IRQ_TX_EMPTY    = 1;
    localparam int unsigned IRQ_PARITY_ERR  = 2;
    localparam int unsigned IRQ_STOP_ERR    = 3;
    localparam int unsigned IRQ_RX_OVERRUN  = 4;
    localparam int unsigned IRQ_TX_OVERFLOW = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

endpackage

// File: rtl/uart_tx_launch.sv
// Launch FSM: pops one character from the Tx FIFO, holds it for the Tx module
// and issues a single start pulse, then waits for the frame to finish.
module uart_tx_launch
    import uart_csr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_pop,
    output logic              tx_start,
    output logic              active,
    output logic [DATA_W-1:0] tx_data
);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [DATA_W-1:0] tx_data_reg;

    // Pop is issued from IDLE so the registered FIFO data lands during POP.
    assign fifo_pop = (state_reg == ST_IDLE) && tx_en && !fifo_empty && !tx_busy;
    assign tx_start = (state_reg == ST_LOAD);
    assign active   = (state_reg != ST_IDLE);
    assign tx_data  = tx_data_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (fifo_pop) state_next = ST_POP;
            ST_POP:  state_next = ST_LOAD;
            ST_LOAD: state_next = ST_WAIT;
            ST_WAIT: if (tx_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            tx_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_POP) tx_data_reg <= fifo_rdata;
        end
    end

endmodule

// File: rtl/uart_csr_ctrl.sv
// CPU-facing UART register block: decodes six registers, strobes the external
// Tx/Rx FIFOs and raises a maskable interrupt from sticky W1C flags.
module uart_csr_ctrl
    import uart_csr_pkg::*;
#(
    parameter int MAX_UART_DATA_W = 8,
    parameter int BAUD_RATE_SEL_W = 2,
    parameter int STOP_CONF_W     = 2,
    parameter int DATA_CONF_W     = 2,
    parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1,
    parameter int CPU_ADDR_WIDTH  = 3,
    parameter int CPU_DATA_WIDTH  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_cpu_i,
    input  logic                       rd_en_cpu_i,
    input  logic [CPU_ADDR_WIDTH-1:0]  cpu_addr_i,
    input  logic [CPU_DATA_WIDTH-1:0]  cpu_data_i,
    output logic [CPU_DATA_WIDTH-1:0]  cpu_data_o,
    output logic                       irq_o,
    input  logic                       tx_busy_i,
    input  logic                       tx_done_i,
    input  logic                       rx_done_i,
    input  logic                       rx_busy_i,
    input  logic                       rx_parity_err_i,
    input  logic                       rx_stop_err_i,
    input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
    input  logic                       tx_fifo_full_i,
    input  logic                       tx_fifo_empty_i,
    input  logic                       rx_fifo_full_i,
    input  logic                       rx_fifo_empty_i,
    output logic                       tx_fifo_push_o,
    output logic                       tx_fifo_pop_o,
    output logic                       rx_fifo_push_o,
    output logic                       rx_fifo_pop_o,
    output logic [MAX_UART_DATA_W-1:0] tx_fifo_wdata_o,
    output logic [MAX_UART_DATA_W-1:0] rx_fifo_wdata_o,
    input  logic [MAX_UART_DATA_W-1:0] tx_fifo_rdata_i,
    input  logic [MAX_UART_DATA_W-1:0] rx_fifo_rdata_i,
    output logic                       tx_start_o,
    output logic [MAX_UART_DATA_W-1:0] tx_data_o,
    output logic                       tx_en_o,
    output logic                       rx_en_o,
    output logic [TOTAL_CONF_W-1:0]    tx_conf_o,
    output logic [TOTAL_CONF_W-1:0]    rx_conf_o,
    output logic [BAUD_RATE_SEL_W-1:0] baud_sel_o
);

    logic                       tx_en_reg;
    logic                       rx_en_reg;
    logic [TOTAL_CONF_W-1:0]    tx_conf_reg;
    logic [TOTAL_CONF_W-1:0]    rx_conf_reg;
    logic [BAUD_RATE_SEL_W-1:0] baud_sel_reg;
    logic [IRQ_SRC_N-1:0]       irq_en_reg;
    logic [IRQ_SRC_N-1:0]       irq_stat_reg;
    logic [IRQ_SRC_N-1:0]       irq_stat_next;
    logic [IRQ_SRC_N-1:0]       irq_set;
    logic [IRQ_SRC_N-1:0]       irq_clr;
    logic                       irq_reg;
    logic                       tx_empty_prev_reg;
    logic                       rx_rd_pending_reg;
    logic [CPU_DATA_WIDTH-1:0]  rd_data_reg;
    logic [CPU_DATA_WIDTH-1:0]  rd_word;
    logic                       launch_active;
    logic                       unused_wdata_bits;

    logic wr_ctrl, wr_txdata, wr_irq_en, wr_irq_stat, rd_rxdata;

    assign wr_ctrl     = wr_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(IDX_CTRL));
    assign wr_txdata   = wr_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(IDX_TXDATA));
    assign wr_irq_en   = wr_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(IDX_IRQ_EN));
    assign wr_irq_stat = wr_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(IDX_IRQ_STAT));
    assign rd_rxdata   = rd_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(IDX_RXDATA));

    assign tx_fifo_push_o  = wr_txdata && !tx_fifo_full_i;
    assign tx_fifo_wdata_o = cpu_data_i[MAX_UART_DATA_W-1:0];
    assign rx_fifo_pop_o   = rd_rxdata && !rx_fifo_empty_i;
    assign rx_fifo_push_o  = rx_done_i && !rx_fifo_full_i;
    assign rx_fifo_wdata_o = rx_data_i;

    assign unused_wdata_bits = ^cpu_data_i;

    assign tx_en_o    = tx_en_reg;
    assign rx_en_o    = rx_en_reg;
    assign tx_conf_o  = tx_conf_reg;
    assign rx_conf_o  = rx_conf_reg;
    assign baud_sel_o = baud_sel_reg;
    assign irq_o      = irq_reg;

    // RXDATA is served straight from the FIFO's registered output one cycle after the pop.
    assign cpu_data_o = rx_rd_pending_reg
                      ? {{(CPU_DATA_WIDTH-MAX_UART_DATA_W){1'b0}}, rx_fifo_rdata_i}
                      : rd_data_reg;

    always_comb begin
        irq_set                  = '0;
        irq_set[IRQ_RX_AVAIL]    = !rx_fifo_empty_i;
        irq_set[IRQ_TX_EMPTY]    = tx_fifo_empty_i && !tx_empty_prev_reg;
        irq_set[IRQ_PARITY_ERR]  = rx_done_i && rx_parity_err_i;
        irq_set[IRQ_STOP_ERR]    = rx_done_i && rx_stop_err_i;
        irq_set[IRQ_RX_OVERRUN]  = rx_done_i && rx_fifo_full_i;
        irq_set[IRQ_TX_OVERFLOW] = wr_txdata && tx_fifo_full_i;
        irq_clr                  = wr_irq_stat ? cpu_data_i[IRQ_SRC_N-1:0] : '0;
        irq_stat_next            = (irq_stat_reg & ~irq_clr) | irq_set;
    end

    always_comb begin
        rd_word = '0;
        case (cpu_addr_i)
            CPU_ADDR_WIDTH'(IDX_STAT): begin
                rd_word[STAT_FSM_ACTIVE] = launch_active;
                rd_word[STAT_TX_BUSY]    = tx_busy_i;
                rd_word[STAT_TX_EMPTY]   = tx_fifo_empty_i;
                rd_word[STAT_TX_FULL]    = tx_fifo_full_i;
                rd_word[STAT_RX_BUSY]    = rx_busy_i;
                rd_word[STAT_RX_EMPTY]   = rx_fifo_empty_i;
                rd_word[STAT_RX_FULL]    = rx_fifo_full_i;
            end
            CPU_ADDR_WIDTH'(IDX_CTRL): begin
                rd_word[CTRL_TX_EN]                         = tx_en_reg;
                rd_word[CTRL_TX_CONF_LSB +: TOTAL_CONF_W]   = tx_conf_reg;
                rd_word[CTRL_RX_EN]                         = rx_en_reg;
                rd_word[CTRL_RX_CONF_LSB +: TOTAL_CONF_W]   = rx_conf_reg;
                rd_word[CTRL_BAUD_LSB +: BAUD_RATE_SEL_W]   = baud_sel_reg;
            end
            CPU_ADDR_WIDTH'(IDX_IRQ_EN):   rd_word[IRQ_SRC_N-1:0] = irq_en_reg;
            CPU_ADDR_WIDTH'(IDX_IRQ_STAT): rd_word[IRQ_SRC_N-1:0] = irq_stat_reg;
            default: ;
        endcase
    end

    // The edge detector starts high so an empty FIFO out of reset is not an event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_en_reg         <= 1'b0;
            rx_en_reg         <= 1'b0;
            tx_conf_reg       <= '0;
            rx_conf_reg       <= '0;
            baud_sel_reg      <= '0;
            irq_en_reg        <= '0;
            irq_stat_reg      <= '0;
            irq_reg           <= 1'b0;
            tx_empty_prev_reg <= 1'b1;
            rx_rd_pending_reg <= 1'b0;
            rd_data_reg       <= '0;
        end else begin
            if (wr_ctrl) begin
                tx_en_reg    <= cpu_data_i[CTRL_TX_EN];
                tx_conf_reg  <= cpu_data_i[CTRL_TX_CONF_LSB +: TOTAL_CONF_W];
                rx_en_reg    <= cpu_data_i[CTRL_RX_EN];
                rx_conf_reg  <= cpu_data_i[CTRL_RX_CONF_LSB +: TOTAL_CONF_W];
                baud_sel_reg <= cpu_data_i[CTRL_BAUD_LSB +: BAUD_RATE_SEL_W];
            end
            if (wr_irq_en) irq_en_reg <= cpu_data_i[IRQ_SRC_N-1:0];
            irq_stat_reg      <= irq_stat_next;
            irq_reg           <= |(irq_stat_reg & irq_en_reg);
            tx_empty_prev_reg <= tx_fifo_empty_i;
            rx_rd_pending_reg <= rx_fifo_pop_o;
            rd_data_reg       <= rd_en_cpu_i ? rd_word : '0;
        end
    end

    uart_tx_launch #(
        .DATA_W (MAX_UART_DATA_W)
    ) u_launch (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .tx_en      (tx_en_reg),
        .fifo_empty (tx_fifo_empty_i),
        .tx_busy    (tx_busy_i),
        .tx_done    (tx_done_i),
        .fifo_rdata (tx_fifo_rdata_i),
        .fifo_pop   (tx_fifo_pop_o),
        .tx_start   (tx_start_o),
        .active     (launch_active),
        .tx_data    (tx_data_o)
    );

endmodule

// File: tb/tb_uart_csr_ctrl.sv
// Bench for uart_csr_ctrl with behavioural FIFOs and Tx module; CPU reads are
// checked through a scoreboard of expected read data.
module tb_uart_csr_ctrl;
    import uart_csr_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        rx_done, rx_busy, rx_perr, rx_serr;
    logic [7:0]  rx_data;
    logic        tx_full = 1'b0, tx_empty = 1'b1, rx_full = 1'b0, rx_empty = 1'b1;
    logic        tx_push, tx_pop, rx_push, rx_pop, tx_start, tx_en, rx_en;
    logic [7:0]  tx_wdata, rx_wdata, tx_data;
    logic [7:0]  tx_rdata = 8'h00, rx_rdata = 8'h00;
    logic [4:0]  tx_conf, rx_conf;
    logic [1:0]  baud;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         frame_len = 3;
    int         tx_cnt = 0;
    int         start_cnt = 0;
    logic       rd_seen = 1'b0;

    always #5 clk = ~clk;

    uart_csr_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .wr_en_cpu_i     (wr_en),
        .rd_en_cpu_i     (rd_en),
        .cpu_addr_i      (addr),
        .cpu_data_i      (wdata),
        .cpu_data_o      (rdata),
        .irq_o           (irq),
        .tx_busy_i       (tx_busy),
        .tx_done_i       (tx_done),
        .rx_done_i       (rx_done),
        .rx_busy_i       (rx_busy),
        .rx_parity_err_i (rx_perr),
        .rx_stop_err_i   (rx_serr),
        .rx_data_i       (rx_data),
        .tx_fifo_full_i  (tx_full),
        .tx_fifo_empty_i (tx_empty),
        .rx_fifo_full_i  (rx_full),
        .rx_fifo_empty_i (rx_empty),
        .tx_fifo_push_o  (tx_push),
        .tx_fifo_pop_o   (tx_pop),
        .rx_fifo_push_o  (rx_push),
        .rx_fifo_pop_o   (rx_pop),
        .tx_fifo_wdata_o (tx_wdata),
        .rx_fifo_wdata_o (rx_wdata),
        .tx_fifo_rdata_i (tx_rdata),
        .rx_fifo_rdata_i (rx_rdata),
        .tx_start_o      (tx_start),
        .tx_data_o       (tx_data),
        .tx_en_o         (tx_en),
        .rx_en_o         (rx_en),
        .tx_conf_o       (tx_conf),
        .rx_conf_o       (rx_conf),
        .baud_sel_o      (baud)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // FIFOs and Tx module: strobes are sampled just before the edge, state updates on it.
    always begin : model
        logic       s_tx_push, s_tx_pop, s_rx_push, s_rx_pop, s_start, s_rd;
        logic [7:0] s_tx_w, s_rx_w, popped;
        @(negedge clk);
        #4;
        s_tx_push = tx_push;  s_tx_pop = tx_pop;  s_tx_w = tx_wdata;
        s_rx_push = rx_push;  s_rx_pop = rx_pop;  s_rx_w = rx_wdata;
        s_start   = tx_start; s_rd     = rd_en;
        @(posedge clk);
        if (s_tx_pop && txq.size() > 0) begin popped = txq.pop_front(); tx_rdata <= popped; end
        if (s_tx_push && txq.size() < FIFO_DEPTH) txq.push_back(s_tx_w);
        if (s_rx_pop && rxq.size() > 0) begin popped = rxq.pop_front(); rx_rdata <= popped; end
        if (s_rx_push && rxq.size() < FIFO_DEPTH) rxq.push_back(s_rx_w);
        tx_empty <= (txq.size() == 0);
        tx_full  <= (txq.size() == FIFO_DEPTH);
        rx_empty <= (rxq.size() == 0);
        rx_full  <= (rxq.size() == FIFO_DEPTH);
        tx_done  <= 1'b0;
        if (s_start) begin
            tx_busy <= 1'b1;
            tx_cnt = frame_len;
            start_cnt++;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
            end
        end
        rd_seen <= s_rd;
    end

    // Read scoreboard: one line per completed read, idle cycles must show zero.
    always @(negedge clk) begin : sb_monitor
        sb_t e;
        if (rd_seen) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("read %-12s data=0x%08h", e.tag, rdata);
                check_val(e.tag, rdata, e.exp);
            end
        end else begin
            check_val("rd_idle_zero", rdata, 32'd0);
        end
    end

    task automatic cyc();
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; rx_done = 1'b0; rx_perr = 1'b0; rx_serr = 1'b0;
    endtask

    task automatic cpu_write(input int unsigned a, input logic [31:0] d);
        cyc();
        wr_en = 1'b1; addr = 3'(a); wdata = d;
        $display("write idx=%0d data=0x%08h", a, d);
    endtask

    task automatic cpu_read(input int unsigned a, input logic [31:0] exp, input string tag);
        sb_t e;
        cyc();
        rd_en = 1'b1; addr = 3'(a);
        e.tag = tag; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic rx_char(input logic [7:0] d, input logic perr);
        cyc();
        rx_done = 1'b1; rx_data = d; rx_perr = perr;
        $display("rx char 0x%02h perr=%0b", d, perr);
    endtask

    initial begin
        logic [31:0] exp_rd;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        rx_done = 1'b0; rx_busy = 1'b0; rx_perr = 1'b0; rx_serr = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_strobes", {tx_push, tx_pop, rx_push, rx_pop, tx_start}, 32'd0);
        check_val("rst_irq", irq, 32'd0);
        check_val("rst_tx_data", tx_data, 32'd0);
        check_val("rst_ctrl_out", {tx_en, rx_en, tx_conf, rx_conf, baud}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register map after reset; only the FIFO empty flags are visible in STAT.
        for (int i = 0; i < 8; i++) begin
            exp_rd = (i == IDX_STAT) ? 32'h0100_0100 : 32'h0;
            cpu_read(i, exp_rd, $sformatf("reset_idx%0d", i));
        end

        cpu_write(IDX_CTRL, 32'h005C_007C);
        cyc(); #1;
        check_val("conf_tx", tx_conf, 32'h1F);
        check_val("conf_rx", rx_conf, 32'h17);
        check_val("conf_en", {tx_en, rx_en}, 32'd0);
        cpu_read(IDX_CTRL, 32'h005C_007C, "ctrl_rb");

        cpu_write(IDX_CTRL, 32'hC001_0001);
        cyc(); #1;
        check_val("baud", baud, 32'd3);
        check_val("enables", {tx_en, rx_en}, 32'b11);
        check_val("conf_cleared", {tx_conf, rx_conf}, 32'd0);

        cpu_write(IDX_TXDATA, 32'h0000_005A); #1;
        check_val("tx_push", tx_push, 32'd1);
        check_val("tx_wdata", tx_wdata, 32'h5A);
        cyc(); #1;
        check_val("tx_pop_n1", tx_pop, 32'd1);
        check_val("tx_start_n1", tx_start, 32'd0);
        cyc(); #1;
        check_val("tx_pop_n2", tx_pop, 32'd0);
        check_val("tx_start_n2", tx_start, 32'd0);
        cyc(); #1;
        check_val("tx_start_n3", tx_start, 32'd1);
        check_val("tx_data", tx_data, 32'h5A);
        for (int i = 0; i < 20 && tx_done !== 1'b1; i++) cyc();
        check_val("tx_done_seen", tx_done, 32'd1);
        repeat (3) cyc();
        check_val("tx_start_once", start_cnt, 32'd1);
        check_val("tx_data_held", tx_data, 32'h5A);

        cpu_write(IDX_IRQ_STAT, 32'h3F);
        cpu_write(IDX_IRQ_EN, 32'h01);
        rx_char(8'hA7, 1'b0); #1;
        check_val("rx_push", rx_push, 32'd1);
        check_val("rx_wdata", rx_wdata, 32'hA7);
        for (int i = 0; i < 6 && irq !== 1'b1; i++) cyc();
        check_val("irq_rx_avail", irq, 32'd1);
        cpu_read(IDX_IRQ_EN, 32'h01, "irq_en_rb");
        cpu_read(IDX_RXDATA, 32'hA7, "rxdata"); #1;
        check_val("rx_pop", rx_pop, 32'd1);
        cpu_read(IDX_RXDATA, 32'h0, "rxdata_empty"); #1;
        check_val("rx_pop_empty", rx_pop, 32'd0);

        cpu_write(IDX_IRQ_STAT, 32'h3F);
        cyc();
        cpu_read(IDX_IRQ_STAT, 32'h00, "irq_clr_all");
        for (int i = 0; i < FIFO_DEPTH; i++) rx_char(8'h10 + 8'(i), 1'b0);
        rx_char(8'hEE, 1'b1); #1;
        check_val("rx_full_nopush", rx_push, 32'd0);
        cyc();
        // rx_avail is also set: a full FIFO is non-empty.
        cpu_read(IDX_IRQ_STAT, 32'h15, "irq_overrun");
        cpu_write(IDX_IRQ_STAT, 32'h14);
        cpu_read(IDX_IRQ_STAT, 32'h01, "irq_w1c");
        cpu_write(IDX_IRQ_STAT, 32'h04);
        rx_done = 1'b1; rx_data = 8'hEF; rx_perr = 1'b1;
        cpu_read(IDX_IRQ_STAT, 32'h15, "irq_set_wins");
        for (int i = 0; i < FIFO_DEPTH; i++) cpu_read(IDX_RXDATA, 32'h10 + i, $sformatf("rx_drain%0d", i));

        cpu_write(IDX_CTRL, 32'h0);
        cpu_write(IDX_IRQ_STAT, 32'h3F);
        for (int i = 0; i < FIFO_DEPTH; i++) cpu_write(IDX_TXDATA, 32'h21 + i);
        cpu_write(IDX_TXDATA, 32'h99); #1;
        check_val("tx_full_nopush", tx_push, 32'd0);
        cyc();
        cpu_read(IDX_IRQ_STAT, 32'h20, "irq_overflow");
        cpu_read(IDX_TXDATA, 32'h0, "txdata_rd");
        cpu_read(IDX_STAT, 32'h0100_0400, "stat_txfull");
        cpu_read(6, 32'h0, "idx6");

        frame_len = 30;
        cpu_write(IDX_CTRL, 32'h1);
        for (int i = 0; i < 10 && tx_start !== 1'b1; i++) cyc();
        check_val("launch2_start", tx_start, 32'd1);
        repeat (3) cyc();
        check_val("launch2_data", tx_data, 32'h21);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        check_val("arst_strobes", {tx_push, tx_pop, tx_start}, 32'd0);
        check_val("arst_tx_data", tx_data, 32'd0);
        check_val("arst_ctrl_out", {tx_en, rx_en, baud}, 32'd0);
        check_val("arst_irq", irq, 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (40) cyc();
        check_val("no_restart", start_cnt, 32'd2);
        cpu_read(IDX_STAT, 32'h0100_0000, "stat_after_rst");
        cpu_write(IDX_CTRL, 32'h1);
        for (int i = 0; i < 10 && tx_start !== 1'b1; i++) cyc();
        check_val("relaunch_start", tx_start, 32'd1);
        check_val("relaunch_data", tx_data, 32'h22);

        repeat (3) cyc();
        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
